// File: rtl/mips_mem_responder_if.sv
// Core-side memory bus plus the byte-serial program-loader stream.
// The master modport is the core/loader side; the slave modport is the responder.
interface mips_mem_responder_if;
    // instruction fetch
    logic [31:0] pc;
    logic [31:0] instr;
    // data access
    logic        memWrite;
    logic [31:0] aluout;
    logic [31:0] writeData;
    logic [31:0] readData;
    // program loader
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output pc, memWrite, aluout, writeData,
        output ld_start, ld_valid, ld_byte, ld_last,
        input  instr, readData, ld_ready
    );

    modport slave (
        input  pc, memWrite, aluout, writeData,
        input  ld_start, ld_valid, ld_byte, ld_last,
        output instr, readData, ld_ready
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Memory-side counterpart of the single-cycle mips core: instruction RAM,
// data RAM, an output register and a cycle counter on the MMIO page, and a
// byte-serial loader that fills instruction RAM while holding the core in reset.
// IMEM_WORDS and DMEM_WORDS must be powers of two and at least 2.
module mips_mem_responder #(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
    input  logic                 clk,
    input  logic                 reset,       // asynchronous, active low
    mips_mem_responder_if.slave  bus,
    output logic                 core_reset,  // active low, 0 holds the core
    output logic                 ld_overflow,
    output logic [31:0]          mmio_out,
    output logic                 run_state
);

    localparam int          IAW        = $clog2(IMEM_WORDS);
    localparam int          DAW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
    localparam logic [31:0] MMIO_CNT   = MMIO_BASE + 32'd4;
    localparam logic [IAW:0] IMEM_FULL = (IAW + 1)'(IMEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_reg;
    logic          core_reset_reg;
    logic          ld_ready_reg;
    logic          run_state_reg;
    logic          ld_overflow_reg;
    logic [IAW:0]  word_addr_reg;   // one extra bit so it can reach IMEM_WORDS
    logic [1:0]    byte_cnt_reg;
    logic [31:0]   asm_reg;
    logic [31:0]   cycle_cnt_reg;
    logic [31:0]   mmio_reg;

    logic [31:0]   imem [IMEM_WORDS];
    logic [31:0]   dmem [DMEM_WORDS];

    logic          byte_accept;
    logic          word_done;
    logic          addr_full;
    logic          imem_we;
    logic [31:0]   asm_next;
    logic [31:0]   alu_word;
    logic          alu_in_dmem;
    logic          store_en;
    logic          store_dmem;
    logic          store_mmio;
    logic [31:0]   read_data;
    logic [31:0]   fetch_data;

    assign core_reset   = core_reset_reg;
    assign ld_overflow  = ld_overflow_reg;
    assign mmio_out     = mmio_reg;
    assign run_state    = run_state_reg;
    assign bus.ld_ready = ld_ready_reg;

    // Loader handshake qualifiers; a word is flushed on its 4th byte or on ld_last.
    assign byte_accept = (state_reg == ST_LOAD) && ld_ready_reg && bus.ld_valid;
    assign word_done   = byte_accept && ((byte_cnt_reg == 2'd3) || bus.ld_last);
    assign addr_full   = (word_addr_reg == IMEM_FULL);
    assign imem_we     = word_done && !addr_full;

    // Big-endian assembly: a fresh word starts from zero so an early ld_last
    // leaves the unfilled low bytes padded with zeros.
    always_comb begin
        asm_next = '0;
        case (byte_cnt_reg)
            2'd0:    asm_next = {bus.ld_byte, 24'h00_0000};
            2'd1:    asm_next = {asm_reg[31:24], bus.ld_byte, 16'h0000};
            2'd2:    asm_next = {asm_reg[31:16], bus.ld_byte, 8'h00};
            default: asm_next = {asm_reg[31:8], bus.ld_byte};
        endcase
    end

    // Store decode; only a running core may modify data RAM or the output register.
    assign alu_word    = {bus.aluout[31:2], 2'b00};
    assign alu_in_dmem = (bus.aluout < DMEM_BYTES);
    assign store_en    = (state_reg == ST_RUN) && bus.memWrite;
    assign store_dmem  = store_en && alu_in_dmem;
    assign store_mmio  = store_en && !alu_in_dmem && (alu_word == MMIO_BASE);

    // Loader FSM with registered handshake/reset outputs and the cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            core_reset_reg  <= 1'b0;
            ld_ready_reg    <= 1'b0;
            run_state_reg   <= 1'b0;
            ld_overflow_reg <= 1'b0;
            word_addr_reg   <= '0;
            byte_cnt_reg    <= '0;
            asm_reg         <= '0;
            cycle_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        state_reg       <= ST_LOAD;
                        ld_ready_reg    <= 1'b1;
                        word_addr_reg   <= '0;
                        byte_cnt_reg    <= '0;
                        asm_reg         <= '0;
                        ld_overflow_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // ld_start is deliberately ignored while a load is in progress
                    if (byte_accept) begin
                        asm_reg      <= asm_next;
                        byte_cnt_reg <= bus.ld_last ? 2'd0 : byte_cnt_reg + 2'd1;
                        if (addr_full) begin
                            ld_overflow_reg <= 1'b1;
                        end else if (word_done) begin
                            word_addr_reg <= word_addr_reg + (IAW + 1)'(1);
                        end
                        if (bus.ld_last) begin
                            state_reg      <= ST_RUN;
                            ld_ready_reg   <= 1'b0;
                            core_reset_reg <= 1'b1;
                            run_state_reg  <= 1'b1;
                            cycle_cnt_reg  <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
                    if (bus.ld_start) begin
                        state_reg       <= ST_LOAD;
                        ld_ready_reg    <= 1'b1;
                        core_reset_reg  <= 1'b0;
                        run_state_reg   <= 1'b0;
                        word_addr_reg   <= '0;
                        byte_cnt_reg    <= '0;
                        asm_reg         <= '0;
                        ld_overflow_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register written by core stores to MMIO_BASE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_reg <= '0;
        end else if (store_mmio) begin
            mmio_reg <= bus.writeData;
        end
    end

    // RAM write ports; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[word_addr_reg[IAW-1:0]] <= asm_next;
        end
        if (store_dmem) begin
            dmem[bus.aluout[DAW+1:2]] <= bus.writeData;
        end
    end

    // Instruction fetch: out-of-range addresses return a nop.
    always_comb begin
        fetch_data = '0;
        if (bus.pc < IMEM_BYTES) begin
            fetch_data = imem[bus.pc[IAW+1:2]];
        end
    end
    assign bus.instr = fetch_data;

    // Load path: data RAM, then the two MMIO words, else zero.
    always_comb begin
        read_data = '0;
        if (alu_in_dmem) begin
            read_data = dmem[bus.aluout[DAW+1:2]];
        end else if (alu_word == MMIO_BASE) begin
            read_data = mmio_reg;
        end else if (alu_word == MMIO_CNT) begin
            read_data = cycle_cnt_reg;
        end
    end
    assign bus.readData = read_data;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized bench for mips_mem_responder with a behavioural model of the
// memories, MMIO words and loader protocol.
`timescale 1ns/1ps
module tb_mips_mem_responder;
    localparam int          IMEM_WORDS = 4;
    localparam int          DMEM_WORDS = 64;
    localparam logic [31:0] MMIO_BASE  = 32'h0000_FF00;
    localparam logic [31:0] MMIO_CNT   = MMIO_BASE + 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_reset;
    logic        ld_overflow;
    logic        run_state;
    logic [31:0] mmio_out;

    mips_mem_responder_if bus();

    mips_mem_responder #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .ld_overflow(ld_overflow),
        .mmio_out   (mmio_out),
        .run_state  (run_state)
    );

    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model
    logic [31:0] m_imem [IMEM_WORDS];
    bit          m_ivalid [IMEM_WORDS];
    logic [31:0] m_dmem [DMEM_WORDS];
    logic [31:0] m_mmio;
    logic [31:0] m_cycle;
    bit          m_run;
    bit          m_ovf;
    logic [7:0]  prog [$];

    // expected load data for an address, from the address map
    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a < 32'(DMEM_WORDS * 4)) return m_dmem[a[7:2]];
        if (w == MMIO_BASE) return m_mmio;
        if (w == MMIO_CNT) return m_cycle;
        return 32'h0;
    endfunction

    // one clock: the counter advances on every edge spent running
    task automatic tick();
        @(posedge clk);
        if (m_run) m_cycle = m_cycle + 32'd1;
        #1;
    endtask

    // drive the program in prog[] through the loader; mid_start pulses a stray ld_start
    task automatic send_program(input bit mid_start);
        int n;
        logic [31:0] w;
        n = prog.size();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        m_run = 0;
        total++;
        if (bus.ld_ready !== 1'b1 || core_reset !== 1'b0 || run_state !== 1'b0) begin
            bad++;
            $display("FAIL load_entry ready=%b core_reset=%b run=%b exp 1/0/0", bus.ld_ready, core_reset, run_state);
        end
        total++;
        if (ld_overflow !== 1'b0) begin
            bad++;
            $display("FAIL load_entry_ovf ld_overflow=%b exp 0", ld_overflow);
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.ld_valid = 1'b0;
                tick();
            end
            bus.ld_valid = 1'b1;
            bus.ld_byte  = prog[i];
            bus.ld_last  = (i == n - 1);
            bus.ld_start = mid_start && (i == 1);
            tick();
            bus.ld_start = 1'b0;
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        m_run   = 1;
        m_cycle = 32'h0;
        for (int wi = 0; (wi * 4 < n) && (wi < IMEM_WORDS); wi++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (wi * 4 + b < n) w[31 - 8 * b -: 8] = prog[wi * 4 + b];
            end
            m_imem[wi]   = w;
            m_ivalid[wi] = 1;
        end
        m_ovf = (n > 4 * IMEM_WORDS);
        total++;
        if (core_reset !== 1'b1 || run_state !== 1'b1 || bus.ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_done core_reset=%b run=%b ready=%b exp 1/1/0", core_reset, run_state, bus.ld_ready);
        end
        total++;
        if (ld_overflow !== m_ovf) begin
            bad++;
            $display("FAIL load_ovf ld_overflow=%b exp %b", ld_overflow, m_ovf);
        end
        $display("load: %0d bytes, mid_start=%0d, overflow=%0d", n, mid_start, ld_overflow);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #10;
        reset = 1'b0;
        m_run = 0; m_cycle = 0; m_mmio = 0; m_ovf = 0;
        repeat (3) tick();
        total++;
        if (core_reset !== 1'b0 || bus.ld_ready !== 1'b0 || run_state !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl core_reset=%b ready=%b run=%b exp 0/0/0", core_reset, bus.ld_ready, run_state);
        end
        total++;
        if (ld_overflow !== 1'b0 || mmio_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_regs ovf=%b mmio=%h exp 0/0", ld_overflow, mmio_out);
        end
        reset = 1'b1;
        repeat (2) tick();
        // stores while idle must be dropped
        bus.memWrite  = 1'b1;
        bus.aluout    = MMIO_BASE;
        bus.writeData = $urandom | 32'h1;
        tick();
        bus.aluout = 32'h0;
        tick();
        bus.memWrite = 1'b0;
        total++;
        if (mmio_out !== m_mmio || core_reset !== 1'b0 || run_state !== 1'b0) begin
            bad++;
            $display("FAIL idle_store mmio=%h core_reset=%b run=%b exp %h/0/0", mmio_out, core_reset, run_state, m_mmio);
        end
        bus.aluout = MMIO_CNT;
        #1;
        total++;
        if (bus.readData !== m_cycle) begin
            bad++;
            $display("FAIL idle_counter got=%h exp=%h", bus.readData, m_cycle);
        end
        $display("reset: idle checks done");
    endtask

    task automatic test_load();
        prog = '{8'h20, 8'h22, 8'h00, 8'h02, 8'h34, 8'h03, 8'h00, 8'h04};
        send_program(1'b0);
        bus.pc = 32'd4;
        #1;
        total++;
        if (bus.instr !== 32'h3403_0004) begin
            bad++;
            $display("FAIL load_pc4 instr=%h exp=34030004", bus.instr);
        end
        bus.pc = 32'd0;
        #1;
        total++;
        if (bus.instr !== 32'h2022_0002) begin
            bad++;
            $display("FAIL load_pc0 instr=%h exp=20220002", bus.instr);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] p;
        for (int i = 0; i < IMEM_WORDS; i++) begin
            if (m_ivalid[i]) begin
                bus.pc = 32'(i * 4) + $urandom_range(0, 3);
                #1;
                total++;
                if (bus.instr !== m_imem[i]) begin
                    bad++;
                    $display("FAIL fetch pc=%h instr=%h exp=%h", bus.pc, bus.instr, m_imem[i]);
                end
            end
        end
        bus.pc = 32'(IMEM_WORDS * 4) + $urandom_range(0, 3);
        #1;
        total++;
        if (bus.instr !== 32'h0) begin
            bad++;
            $display("FAIL fetch_edge pc=%h instr=%h exp=0", bus.pc, bus.instr);
        end
        p = $urandom | 32'h0000_1000;
        bus.pc = p;
        #1;
        total++;
        if (bus.instr !== 32'h0) begin
            bad++;
            $display("FAIL fetch_far pc=%h instr=%h exp=0", bus.pc, bus.instr);
        end
        $display("fetch: checked pc window");
    endtask

    task automatic test_partial();
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_program(1'b1);
        bus.pc = 32'd4;
        #1;
        total++;
        if (bus.instr !== 32'hEE00_0000) begin
            bad++;
            $display("FAIL partial_word instr=%h exp=EE000000", bus.instr);
        end
    endtask

    task automatic test_data_mmio();
        logic [31:0] a, d;
        int k, kind;
        // give every data word a known value
        bus.memWrite = 1'b1;
        for (int i = 0; i < DMEM_WORDS; i++) begin
            bus.aluout    = 32'(i * 4);
            bus.writeData = $urandom;
            m_dmem[i]     = bus.writeData;
            tick();
        end
        bus.memWrite = 1'b0;
        k = $urandom_range(1, 8);
        repeat (k) tick();
        bus.aluout = MMIO_CNT;
        #1;
        total++;
        if (bus.readData !== m_cycle) begin
            bad++;
            $display("FAIL counter got=%0d exp=%0d", bus.readData, m_cycle);
        end
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            d = $urandom;
            case (kind)
                0, 1:    a = $urandom_range(0, DMEM_WORDS * 4 - 1);
                2:       a = MMIO_BASE;
                3:       a = MMIO_CNT;
                4:       a = $urandom_range(32'h100, 32'hFEFF);
                default: a = 32'd8;
            endcase
            if (it == 0) begin a = 32'd8; d = 32'hDEAD_BEEF; end
            if (it == 1) begin a = MMIO_BASE; d = 32'h5; end
            bus.memWrite  = 1'b1;
            bus.aluout    = a;
            bus.writeData = d;
            #1;
            total++;
            if (bus.readData !== m_read(a)) begin
                bad++;
                $display("FAIL same_cycle_old addr=%h got=%h exp=%h", a, bus.readData, m_read(a));
            end
            tick();
            if (a < 32'(DMEM_WORDS * 4)) m_dmem[a[7:2]] = d;
            else if (a == MMIO_BASE) m_mmio = d;
            bus.memWrite = 1'b0;
            #1;
            total++;
            if (bus.readData !== m_read(a)) begin
                bad++;
                $display("FAIL readback addr=%h got=%h exp=%h", a, bus.readData, m_read(a));
            end
            total++;
            if (mmio_out !== m_mmio) begin
                bad++;
                $display("FAIL mmio_out got=%h exp=%h", mmio_out, m_mmio);
            end
            bus.aluout = MMIO_CNT | 32'($urandom_range(0, 3));
            #1;
            total++;
            if (bus.readData !== m_cycle) begin
                bad++;
                $display("FAIL counter_run got=%0d exp=%0d", bus.readData, m_cycle);
            end
            $display("store: addr=%h data=%h readback=%h cycle=%0d", a, d, m_read(a), m_cycle);
        end
    endtask

    task automatic test_overflow();
        prog.delete();
        for (int i = 0; i < 20; i++) prog.push_back(8'($urandom));
        send_program(1'b0);
        total++;
        if (ld_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set ld_overflow=%b exp 1", ld_overflow);
        end
        for (int i = 0; i < IMEM_WORDS; i++) begin
            bus.pc = 32'(i * 4);
            #1;
            total++;
            if (bus.instr !== {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]}) begin
                bad++;
                $display("FAIL overflow_keep pc=%h instr=%h exp=%h", bus.pc, bus.instr,
                         {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]});
            end
        end
        // exactly filling the RAM is not an overflow
        prog.delete();
        for (int i = 0; i < 4 * IMEM_WORDS; i++) prog.push_back(8'($urandom));
        send_program(1'b0);
    endtask

    task automatic test_reload_reset();
        logic [31:0] a0;
        a0 = $urandom;
        bus.memWrite  = 1'b1;
        bus.aluout    = 32'h0;
        bus.writeData = a0;
        tick();
        m_dmem[0] = a0;
        bus.memWrite = 1'b0;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        m_run = 0;
        total++;
        if (core_reset !== 1'b0 || run_state !== 1'b0 || bus.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL reload_entry core_reset=%b run=%b ready=%b exp 0/0/1", core_reset, run_state, bus.ld_ready);
        end
        // stores during a load are dropped
        bus.memWrite  = 1'b1;
        bus.aluout    = 32'h0;
        bus.writeData = ~a0;
        tick();
        bus.aluout = MMIO_BASE;
        tick();
        bus.memWrite = 1'b0;
        bus.aluout   = 32'h0;
        #1;
        total++;
        if (bus.readData !== a0 || mmio_out !== m_mmio) begin
            bad++;
            $display("FAIL load_store_drop rd=%h mmio=%h exp %h/%h", bus.readData, mmio_out, a0, m_mmio);
        end
        // six bytes: one full word lands, the partial second word must be lost
        prog.delete();
        for (int i = 0; i < 6; i++) prog.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_byte  = prog[i];
            tick();
        end
        bus.ld_valid = 1'b0;
        m_imem[0] = {prog[0], prog[1], prog[2], prog[3]};
        @(posedge clk);
        #20;
        reset = 1'b0;
        #1;
        m_mmio = 0; m_cycle = 0; m_ovf = 0;
        total++;
        if (bus.ld_ready !== 1'b0 || core_reset !== 1'b0 || run_state !== 1'b0) begin
            bad++;
            $display("FAIL async_reset ready=%b core_reset=%b run=%b exp 0/0/0", bus.ld_ready, core_reset, run_state);
        end
        tick();
        reset = 1'b1;
        bus.memWrite  = 1'b1;
        bus.aluout    = 32'h0;
        bus.writeData = ~a0;
        tick();
        bus.memWrite = 1'b0;
        #1;
        total++;
        if (bus.readData !== a0) begin
            bad++;
            $display("FAIL idle_store_drop rd=%h exp=%h", bus.readData, a0);
        end
        for (int i = 0; i < 2; i++) begin
            bus.pc = 32'(i * 4);
            #1;
            total++;
            if (bus.instr !== m_imem[i]) begin
                bad++;
                $display("FAIL reset_imem pc=%h instr=%h exp=%h", bus.pc, bus.instr, m_imem[i]);
            end
        end
        prog = '{8'h11, 8'h22, 8'h33};
        send_program(1'b0);
        bus.aluout = 32'h0;
        #1;
        total++;
        if (bus.readData !== a0 || mmio_out !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_run rd=%h mmio=%h exp %h/0", bus.readData, mmio_out, a0);
        end
        $display("reload/reset: done");
    endtask

    initial begin
        bus.pc        = 32'h0;
        bus.memWrite  = 1'b0;
        bus.aluout    = 32'h0;
        bus.writeData = 32'h0;
        bus.ld_start  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_byte   = 8'h0;
        bus.ld_last   = 1'b0;
        for (int i = 0; i < IMEM_WORDS; i++) m_ivalid[i] = 0;
        for (int i = 0; i < DMEM_WORDS; i++) m_dmem[i] = 32'h0;
        test_reset();
        test_load();
        test_fetch();
        test_partial();
        test_fetch();
        test_data_mmio();
        test_overflow();
        test_fetch();
        test_reload_reset();
        test_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
